// File: rtl/instr_sequencer.sv
// Fetch/decode/issue sequencer: fetches instructions, resolves jumps and HALT locally,
// and issues all other opcodes to the datapath through an exec_en/exec_done handshake.
module instr_sequencer #(
  parameter int PC_W       = 8,
  parameter int CNT_W      = 16,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      ir,
  output logic             exec_en,
  input  logic             exec_done,
  input  logic             flag_zero,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] instr_count,
  output logic             busy,
  output logic             halted,
  output logic             err
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);
  localparam logic [PC_W-1:0]   PC_START  = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_JZ   = 5'd13;
  localparam logic [4:0] OP_JNZ  = 5'd14;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALTED} state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc_nx;
  logic [31:0]       ir_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              err_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic [4:0]        oper;
  logic [PC_W-1:0]   target;

  assign oper   = ir[31:27];
  assign target = PC_W'(ir[15:0]);

  // Next-state and register update logic for the whole sequencer.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    cnt_nx   = instr_count;
    err_nx   = err;
    wait_nx  = wait_cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nx = FETCH;
          pc_nx    = PC_START;
          err_nx   = 1'b0;
          cnt_nx   = '0;
          wait_nx  = '0;
        end else begin
          state_nx = state;
        end
      end
      FETCH: begin
        if (imem_valid) begin
          ir_nx    = imem_rdata;
          wait_nx  = '0;
          state_nx = DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          wait_nx  = '0;
          state_nx = HALTED;
        end else begin
          wait_nx  = wait_cnt + 1'b1;
        end
      end
      DECODE: begin
        case (oper)
          OP_JMP: begin
            pc_nx    = target;
            cnt_nx   = instr_count + CNT_ONE;
            state_nx = FETCH;
          end
          OP_JZ: begin
            pc_nx    = flag_zero ? target : pc + PC_ONE;
            cnt_nx   = instr_count + CNT_ONE;
            state_nx = FETCH;
          end
          OP_JNZ: begin
            pc_nx    = !flag_zero ? target : pc + PC_ONE;
            cnt_nx   = instr_count + CNT_ONE;
            state_nx = FETCH;
          end
          OP_HALT: begin
            cnt_nx   = instr_count + CNT_ONE;
            state_nx = HALTED;
          end
          default: state_nx = EXEC;
        endcase
      end
      EXEC: begin
        if (exec_done) begin
          pc_nx    = pc + PC_ONE;
          cnt_nx   = instr_count + CNT_ONE;
          state_nx = FETCH;
        end else begin
          state_nx = EXEC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and architectural registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      ir          <= ir_nx;
      instr_count <= cnt_nx;
      err         <= err_nx;
      wait_cnt    <= wait_nx;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign exec_en   = (state == EXEC);
  assign busy      = (state != IDLE) && (state != HALTED);
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected fetch addresses
// and issues into queues; monitors pop and compare when the DUT fetches or issues.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        sys_rst, start, flag_zero;
  logic        imem_req, imem_valid, exec_en, exec_done;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata, ir;
  logic [15:0] instr_count;
  logic        busy, halted, err;

  logic        rst2, start2, imem_req2, exec_en2, busy2, halted2, err2;
  logic [3:0]  imem_addr2, pc2;
  logic [31:0] ir2;
  logic [15:0] cnt2;

  typedef struct { logic [31:0] ir; logic [7:0] pc; int len; } issue_t;
  issue_t      exec_q[$];
  logic [7:0]  fetch_q[$];
  logic [3:0]  fetch2_q[$];

  logic [31:0] mem [0:255];
  logic        ok_map [0:255];
  int          done_delay = 0;
  int          ecnt = 0;
  int          n_checks = 0, n_pass = 0;
  int          run_len = 0;
  logic [31:0] ir_first;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ir(ir), .exec_en(exec_en),
    .exec_done(exec_done), .flag_zero(flag_zero), .pc(pc), .instr_count(instr_count),
    .busy(busy), .halted(halted), .err(err)
  );

  instr_sequencer #(.PC_W(4)) dut2 (
    .clk(clk), .sys_rst(rst2), .start(start2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(32'h0000_0000), .imem_valid(imem_req2), .ir(ir2), .exec_en(exec_en2),
    .exec_done(exec_en2), .flag_zero(1'b0), .pc(pc2), .instr_count(cnt2),
    .busy(busy2), .halted(halted2), .err(err2)
  );

  // Memory and datapath models.
  always_comb begin
    imem_rdata = mem[imem_addr];
    imem_valid = imem_req && ok_map[imem_addr];
    exec_done  = exec_en && (ecnt >= done_delay);
  end

  always @(posedge clk) ecnt <= (exec_en && !exec_done) ? ecnt + 1 : 0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] isrc);
    return {op, 11'd0, isrc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for the main DUT: fetch addresses, issue contents, exec_en length, ir stability.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (imem_req && imem_valid) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", {24'd0, imem_addr}, 32'hFFFF_FFFF);
        else chk("fetch_addr", {24'd0, imem_addr}, {24'd0, fetch_q.pop_front()});
      end
      if (exec_en) begin
        if (run_len == 0) ir_first = ir;
        else if (ir !== ir_first) chk("ir_stable", ir, ir_first);
        run_len++;
        if (exec_done) begin
          if (exec_q.size() == 0) chk("issue_unexpected", ir, 32'hFFFF_FFFF);
          else begin
            issue_t e;
            e = exec_q.pop_front();
            chk("issue_ir", ir, e.ir);
            chk("issue_pc", {24'd0, pc}, {24'd0, e.pc});
            chk("exec_len", run_len, e.len);
          end
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  // Monitor for the 4-bit PC instance.
  always @(negedge clk) begin
    if (!rst2 && imem_req2 && fetch2_q.size() > 0) begin
      logic [3:0] a;
      a = fetch2_q.pop_front();
      chk("wrap_addr", {28'd0, imem_addr2}, {28'd0, a});
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic run_expect(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] pc_e,
                            input string tag);
    int c;
    fetch_q.push_back(a0);
    fetch_q.push_back(a1);
    pulse_start();
    wait_halt(50, c);
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, pc_e});
    chk({tag, "_count"}, {16'd0, instr_count}, 32'd2);
  endtask

  // DUT2: NOP stream through PC wrap with a stray start mid-run.
  initial begin
    rst2 = 1'b1; start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 18; i++) fetch2_q.push_back(4'(i));
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    repeat (10) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  end

  initial begin
    int c;
    for (int i = 0; i < 256; i++) begin
      mem[i] = mk(5'd31, 16'd0);
      ok_map[i] = 1'b1;
    end
    sys_rst = 1'b1; start = 1'b0; flag_zero = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_exec_en", {31'd0, exec_en}, 32'd0);
    chk("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
    chk("rst_pc_cnt_err", {7'd0, pc, instr_count, err}, 32'd0);
    chk("rst_ir", ir, 32'd0);

    // Reset in the middle of a long EXEC after a jump.
    mem[0] = mk(5'd12, 16'd4);
    mem[4] = mk(5'd1, 16'h1234);
    done_delay = 1000;
    fetch_q.push_back(8'd0);
    fetch_q.push_back(8'd4);
    pulse_start();
    for (int i = 0; i < 20 && !exec_en; i++) @(negedge clk);
    chk("midexec_exec_en", {31'd0, exec_en}, 32'd1);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    chk("midrst_exec_en", {31'd0, exec_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    chk("midrst_count", {16'd0, instr_count}, 32'd0);

    // Straight line: MUL r1,r3,r2 then HALT.
    mem[0] = {5'd2, 5'd1, 5'd3, 1'b0, 5'd2, 11'd0};
    mem[1] = mk(5'd31, 16'd0);
    done_delay = 0;
    exec_q.push_back('{ir: mem[0], pc: 8'd0, len: 1});
    fetch_q.push_back(8'd0);
    fetch_q.push_back(8'd1);
    pulse_start();
    chk("req_after_start", {31'd0, imem_req}, 32'd1);
    wait_halt(50, c);
    chk("halt_latency", c, 32'd5);
    chk("line_pc", {24'd0, pc}, 32'd1);
    chk("line_count", {16'd0, instr_count}, 32'd2);
    chk("line_busy", {31'd0, busy}, 32'd0);

    // Branches: taken/untaken JZ, JNZ taken, JMP with truncated target.
    mem[0] = mk(5'd13, 16'd5);
    flag_zero = 1'b1;
    run_expect(8'd0, 8'd5, 8'd5, "jz_taken");
    flag_zero = 1'b0;
    run_expect(8'd0, 8'd1, 8'd1, "jz_untaken");
    mem[0] = mk(5'd14, 16'd7);
    run_expect(8'd0, 8'd7, 8'd7, "jnz_taken");
    mem[0] = mk(5'd12, 16'h0103);
    run_expect(8'd0, 8'd3, 8'd3, "jmp_trunc");

    // Multi-cycle exec with a stray start while busy.
    mem[0] = {5'd1, 5'd4, 5'd5, 1'b1, 16'h00AA};
    done_delay = 3;
    exec_q.push_back('{ir: mem[0], pc: 8'd0, len: 4});
    fetch_q.push_back(8'd0);
    fetch_q.push_back(8'd1);
    pulse_start();
    for (int i = 0; i < 20 && !exec_en; i++) @(negedge clk);
    pulse_start();
    chk("stray_pc", {24'd0, pc}, 32'd0);
    chk("stray_count", {16'd0, instr_count}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd1);
    wait_halt(50, c);
    chk("multi_pc", {24'd0, pc}, 32'd1);
    chk("multi_count", {16'd0, instr_count}, 32'd2);
    done_delay = 0;

    // Fetch timeout at a jump target that never answers.
    mem[0] = mk(5'd12, 16'd9);
    ok_map[9] = 1'b0;
    fetch_q.push_back(8'd0);
    pulse_start();
    c = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      if (imem_req && !imem_valid) c++;
      @(negedge clk);
    end
    chk("timeout_cycles", c, 32'd15);
    chk("timeout_err", {30'd0, err, halted}, 32'd3);
    chk("timeout_pc", {24'd0, pc}, 32'd9);
    chk("timeout_count", {16'd0, instr_count}, 32'd1);
    ok_map[9] = 1'b1;
    mem[9] = mk(5'd31, 16'd0);
    fetch_q.push_back(8'd0);
    fetch_q.push_back(8'd9);
    pulse_start();
    chk("restart_err", {31'd0, err}, 32'd0);
    chk("restart_pc", {24'd0, pc}, 32'd0);
    wait_halt(50, c);
    chk("restart_final_pc", {24'd0, pc}, 32'd9);

    for (int i = 0; i < 200 && fetch2_q.size() > 0; i++) @(negedge clk);
    chk("wrap_drained", fetch2_q.size(), 32'd0);
    chk("fetch_q_empty", fetch_q.size(), 32'd0);
    chk("exec_q_empty", exec_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
